// File: rtl/td4_pkg.sv
// Shared TD4 constants and the instruction-memory loader state encoding.
// TD4_IMEM_CHECKSUM_EN adds the CHECK state used by the checksum build.
package td4_pkg;
  localparam int TD4_AW         = 4;
  localparam int TD4_DW         = 8;
  localparam int TD4_IMEM_DEPTH = 16;

`ifdef TD4_IMEM_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } imem_ld_state_t;
`else
  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } imem_ld_state_t;
`endif
endpackage

// File: rtl/td4_imem_array.sv
// 2^AW x DW register file: one synchronous write port, one combinational
// read port, whole array cleared asynchronously by rst.
module td4_imem_array
  import td4_pkg::*;
#(
  parameter int AW = TD4_AW,
  parameter int DW = TD4_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0][DW-1:0] mem;

  genvar w;
  generate
    for (w = 0; w < DEPTH; w++) begin : g_word
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          mem[w] <= '0;
        else if (we && waddr == AW'(w))
          mem[w] <= wdata;
      end
    end
  endgenerate

  assign rdata = mem[raddr];
endmodule

// File: rtl/td4_imem_loader.sv
// Writable TD4 instruction memory with a byte-wide valid/ready image loader.
// Holds the core in reset until a full image is present. Define
// TD4_IMEM_CHECKSUM_EN to require a trailing checksum byte.
module td4_imem_loader
  import td4_pkg::*;
#(
  parameter int AW = TD4_AW,
  parameter int DW = TD4_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          cpu_rst,
  output logic          busy,
  output logic          err
);
  imem_ld_state_t state;
  logic [AW-1:0]  cnt;
  logic           accept;
  logic           we;
  logic           last_byte;

  // ld_ready is a pure state decode, so accept never loops back through it
  assign accept    = ld_valid && ld_ready;
  assign we        = accept && !ld_start && (state == ST_LOAD);
  assign last_byte = (cnt == AW'(2 ** AW - 1));

  td4_imem_array #(.AW(AW), .DW(DW)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (cnt),
    .wdata (ld_data),
    .raddr (addr),
    .rdata (data)
  );

`ifdef TD4_IMEM_CHECKSUM_EN
  logic [DW-1:0] sum;
  logic          err_q;
  logic [DW-1:0] sum_next;

  assign sum_next = sum + ld_data;
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      cnt      <= '0;
      cpu_rst  <= 1'b1;
      ld_ready <= 1'b0;
      busy     <= 1'b0;
`ifdef TD4_IMEM_CHECKSUM_EN
      sum      <= '0;
      err_q    <= 1'b0;
`endif
    end else if (ld_start) begin
      // start wins over a simultaneous byte in every state
      state    <= ST_LOAD;
      cnt      <= '0;
      cpu_rst  <= 1'b1;
      ld_ready <= 1'b1;
      busy     <= 1'b1;
`ifdef TD4_IMEM_CHECKSUM_EN
      sum      <= '0;
      err_q    <= 1'b0;
`endif
    end else if (accept) begin
      case (state)
        ST_LOAD: begin
          cnt <= cnt + 1'b1;
`ifdef TD4_IMEM_CHECKSUM_EN
          sum <= sum_next;
          if (last_byte)
            state <= ST_CHECK;
`else
          if (last_byte) begin
            state    <= ST_RUN;
            cpu_rst  <= 1'b0;
            ld_ready <= 1'b0;
            busy     <= 1'b0;
          end
`endif
        end
`ifdef TD4_IMEM_CHECKSUM_EN
        ST_CHECK: begin
          ld_ready <= 1'b0;
          busy     <= 1'b0;
          if (sum_next == '0) begin
            state   <= ST_RUN;
            cpu_rst <= 1'b0;
          end else begin
            state   <= ST_ERROR;
            cpu_rst <= 1'b1;
            err_q   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_td4_imem_loader.sv
// Directed self-checking bench for td4_imem_loader (default and
// TD4_IMEM_CHECKSUM_EN builds).
module tb_td4_imem_loader;
`ifdef TD4_IMEM_CHECKSUM_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] addr = '0;
  logic [7:0] data;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_ready, cpu_rst, busy, err;

  int nchk = 0;
  int nfail = 0;

  td4_imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data     (data),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // appends the two's-complement checksum byte in the checksum build
  task automatic finish_image(inout logic [7:0] img[NB]);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + img[i];
    if (NB > 16) img[NB-1] = 8'h00 - s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    nchk++; if (cpu_rst !== 1'b1) begin nfail++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
    nchk++; if (ld_ready !== 1'b0) begin nfail++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
    nchk++; if (busy !== 1'b0 || err !== 1'b0) begin nfail++; $display("FAIL reset_busy_err got=%b%b exp=00", busy, err); end
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #0.5;
      nchk++; if (data !== 8'h00) begin nfail++; $display("FAIL reset_data addr=%0d got=%h exp=00", a, data); end
    end
    @(negedge clk);
    rst = 1'b0;
    step(); step();
    nchk++; if (cpu_rst !== 1'b1 || busy !== 1'b0 || ld_ready !== 1'b0) begin
      nfail++; $display("FAIL post_reset_empty got cpu_rst=%b busy=%b ready=%b exp 1/0/0", cpu_rst, busy, ld_ready);
    end
  endtask

  task automatic test_full_load();
    logic [7:0] img[NB];
    for (int i = 0; i < NB; i++) img[i] = (i == 0) ? 8'hB3 : 8'(i);
    finish_image(img);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    nchk++; if (busy !== 1'b1 || ld_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      nfail++; $display("FAIL load_enter got busy=%b ready=%b cpu_rst=%b exp 1/1/1", busy, ld_ready, cpu_rst);
    end
    for (int i = 0; i < NB; i++) begin
      ld_valid = 1'b1;
      ld_data  = img[i];
      addr     = 4'(i);
      step();
      if (i < 16) begin
        nchk++; if (data !== img[i]) begin nfail++; $display("FAIL load_write addr=%0d got=%h exp=%h", i, data, img[i]); end
      end
      if (i == NB - 2) begin
        nchk++; if (cpu_rst !== 1'b1) begin nfail++; $display("FAIL load_early_run got cpu_rst=%b exp=1", cpu_rst); end
      end
    end
    ld_valid = 1'b0;
    nchk++; if (cpu_rst !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b0 || err !== 1'b0) begin
      nfail++; $display("FAIL load_run got cpu_rst=%b busy=%b ready=%b err=%b exp 0/0/0/0", cpu_rst, busy, ld_ready, err);
    end
    addr = 4'd0; #1;
    nchk++; if (data !== 8'hB3) begin nfail++; $display("FAIL load_addr0 got=%h exp=b3", data); end
    addr = 4'd1; #1;
    nchk++; if (data !== 8'h01) begin nfail++; $display("FAIL load_addr1 got=%h exp=01", data); end
    // bytes outside LOAD are ignored
    ld_valid = 1'b1; ld_data = 8'h5A; addr = 4'd0;
    step();
    ld_valid = 1'b0;
    nchk++; if (data !== 8'hB3 || cpu_rst !== 1'b0) begin nfail++; $display("FAIL run_ignore got data=%h cpu_rst=%b exp b3/0", data, cpu_rst); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] img[NB];
    int k;
    for (int i = 0; i < NB; i++) img[i] = 8'hA0 ^ 8'(i);
    finish_image(img);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    k = 0;
    for (int c = 0; c < 2 * NB; c++) begin
      ld_valid = (c % 2 == 0);
      ld_data  = ld_valid ? img[c/2] : 8'hEE;
      step();
      if (c == 2 * NB - 4) begin
        nchk++; if (cpu_rst !== 1'b1 || busy !== 1'b1) begin nfail++; $display("FAIL bp_mid got cpu_rst=%b busy=%b exp 1/1", cpu_rst, busy); end
      end
    end
    ld_valid = 1'b0;
    nchk++; if (cpu_rst !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL bp_done got cpu_rst=%b busy=%b exp 0/0", cpu_rst, busy); end
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a); #0.5;
      if (data !== img[a]) k++;
    end
    nchk++; if (k != 0) begin nfail++; $display("FAIL bp_contents got %0d bad words exp 0", k); end
  endtask

  task automatic test_restart();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1; ld_data = 8'h50 + 8'(i);
      step();
    end
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hFF;
    step();
    ld_start = 1'b0;
    addr = 4'd7; #0.5;
    nchk++; if (data !== 8'hA7) begin nfail++; $display("FAIL restart_drop addr7 got=%h exp=a7", data); end
    nchk++; if (busy !== 1'b1 || cpu_rst !== 1'b1) begin nfail++; $display("FAIL restart_state got busy=%b cpu_rst=%b exp 1/1", busy, cpu_rst); end
    ld_data = 8'h3C;
    step();
    addr = 4'd0; #0.5;
    nchk++; if (data !== 8'h3C) begin nfail++; $display("FAIL restart_addr0 got=%h exp=3c", data); end
    addr = 4'd1; #0.5;
    nchk++; if (data !== 8'h51) begin nfail++; $display("FAIL restart_addr1 got=%h exp=51", data); end
    for (int i = 1; i < NB; i++) begin
      ld_data = (i < 16) ? 8'h00 : 8'hC4;  // image 3C,0.. -> checksum C4
      step();
    end
    ld_valid = 1'b0;
    nchk++; if (cpu_rst !== 1'b0 || err !== 1'b0) begin nfail++; $display("FAIL restart_run got cpu_rst=%b err=%b exp 0/0", cpu_rst, err); end
  endtask

`ifdef TD4_IMEM_CHECKSUM_EN
  task automatic test_checksum();
    for (int pass = 0; pass < 2; pass++) begin
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      for (int i = 0; i < 17; i++) begin
        ld_valid = 1'b1;
        ld_data  = (i < 16) ? 8'h04 : (pass == 0 ? 8'hC0 : 8'hC1);
        step();
        if (i == 15) begin
          nchk++; if (ld_ready !== 1'b1 || cpu_rst !== 1'b1) begin nfail++; $display("FAIL cks_check_state got ready=%b cpu_rst=%b exp 1/1", ld_ready, cpu_rst); end
        end
      end
      ld_valid = 1'b0;
      step(); step();
      if (pass == 0) begin
        nchk++; if (cpu_rst !== 1'b0 || err !== 1'b0) begin nfail++; $display("FAIL cks_good got cpu_rst=%b err=%b exp 0/0", cpu_rst, err); end
      end else begin
        nchk++; if (cpu_rst !== 1'b1 || err !== 1'b1 || ld_ready !== 1'b0) begin nfail++; $display("FAIL cks_bad got cpu_rst=%b err=%b ready=%b exp 1/1/0", cpu_rst, err, ld_ready); end
      end
    end
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    nchk++; if (err !== 1'b0 || busy !== 1'b1) begin nfail++; $display("FAIL cks_restart got err=%b busy=%b exp 0/1", err, busy); end
  endtask
`endif

  task automatic test_async_reset();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ld_valid = 1'b1; ld_data = 8'h90 + 8'(i);
      step();
    end
    addr = 4'd3; #0.5;
    nchk++; if (data !== 8'h93) begin nfail++; $display("FAIL areset_pre got=%h exp=93", data); end
    #2 rst = 1'b1;
    #1;
    nchk++; if (cpu_rst !== 1'b1 || ld_ready !== 1'b0 || busy !== 1'b0) begin
      nfail++; $display("FAIL areset_outputs got cpu_rst=%b ready=%b busy=%b exp 1/0/0", cpu_rst, ld_ready, busy);
    end
    nchk++; if (data !== 8'h00) begin nfail++; $display("FAIL areset_data_now got=%h exp=00", data); end
    ld_valid = 1'b0;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a); #0.5;
      nchk++; if (data !== 8'h00) begin nfail++; $display("FAIL areset_mem addr=%0d got=%h exp=00", a, data); end
    end
    @(negedge clk);
    rst = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h77; addr = 4'd0;
    step(); step();
    ld_valid = 1'b0;
    nchk++; if (data !== 8'h00 || cpu_rst !== 1'b1 || ld_ready !== 1'b0) begin
      nfail++; $display("FAIL empty_ignore got data=%h cpu_rst=%b ready=%b exp 00/1/0", data, cpu_rst, ld_ready);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_back_pressure();
    test_restart();
`ifdef TD4_IMEM_CHECKSUM_EN
    test_checksum();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/td4_imem_loader.md
# td4_imem_loader

Writable 16x8 instruction memory for the TD4 core, replacing the fixed `imem` ROM directly upstream of `td4`. It serves combinational instruction fetch on `addr`/`data` and accepts a program image over a byte-wide valid/ready load port. While no valid image is present, it holds the CPU in reset through `cpu_rst`, so a program can be (re)loaded at any time without touching the top-level reset.

## Interface
- `AW`, 4: instruction address width; depth is 2^AW = 16 words.
- `DW`, 8: instruction word width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  AW  fetch address from `td4`.
- `data`  out  DW  instruction word at `addr`; combinational.
- `ld_start`  in  1  one-cycle pulse that begins a new image load.
- `ld_valid`  in  1  `ld_data` is valid.
- `ld_data`  in  DW  image byte.
- `ld_ready`  out  1  loader accepts a byte this cycle.
- `cpu_rst`  out  1  reset to `td4`; high whenever no valid image is present.
- `busy`  out  1  a load is in progress.
- `err`  out  1  the last load failed the checksum. Tied to 0 when checksum is compiled out.

## Operation
- States:
  - EMPTY: `cpu_rst`=1, waiting for `ld_start`.
  - LOAD: `ld_ready`=1, `busy`=1.
  - CHECK: checksum only; `ld_ready`=1, `busy`=1.
  - RUN: `cpu_rst`=0.
  - ERROR: `cpu_rst`=1, `err`=1.
- Reset value of every output:
  - state EMPTY, byte counter 0, all memory words 8'h00.
  - `cpu_rst`=1, `ld_ready`=0, `busy`=0, `err`=0.
  - `data` = 8'h00 for every `addr`.
- `ld_start` in any state moves to LOAD, clears the counter to 0, and clears the running sum and `err`.
- Transfer rule: a byte is accepted only when `ld_valid` && `ld_ready`. The accepted byte is written to mem[counter] and the counter increments.
- LOAD → RUN once byte 15 is accepted. With checksum compiled in, LOAD → CHECK instead.
- CHECK accepts exactly one more byte. If (sum of the 16 image bytes + checksum byte) mod 256 == 0, go to RUN; otherwise go to ERROR.
- ERROR and EMPTY leave only on `ld_start`.
- Simultaneous `ld_start` and `ld_valid`: start wins; the byte is dropped and is not written.
- Counter arithmetic is AW bits and wraps at 15. Wrap-around never causes a write, because byte 15 always changes state.
- `ld_valid` outside LOAD/CHECK is ignored.
- `data` = mem[`addr`] always, including mid-load. Partially written content is visible, but the CPU is held in reset during that time.

## Timing
- Fetch latency: 0 cycles (combinational read).
- `cpu_rst` rises on the first edge after an accepted `ld_start`.
- `cpu_rst` falls on the edge that accepts the final byte (byte 15, or the checksum byte). `td4` leaves reset in the next cycle, fetching address 0.
- A byte written at edge N appears on `data` immediately after edge N.
- Minimum load duration:
  - 16 cycles after the `ld_start` cycle.
  - 17 cycles with checksum.
- `rst` asserted mid-load aborts the load immediately and asynchronously. All state returns to the reset values, including clearing memory.
- `ld_ready` is a registered state decode and does not depend on `ld_valid`.

## Configuration
- `TD4_IMEM_CHECKSUM_EN` defined:
  - CHECK state is present.
  - A 17th byte is required.
  - `err` is driven as described in Operation.
- `TD4_IMEM_CHECKSUM_EN` undefined:
  - No CHECK state and no sum register.
  - LOAD goes straight to RUN after 16 bytes.
  - `err` is constant 0.

## Structure
- Shared package `td4_pkg`:
  - state enum `imem_ld_state_t`.
  - constants `TD4_AW`=4, `TD4_DW`=8, `TD4_IMEM_DEPTH`=16.
- Sub-module `td4_imem_array`: 16xDW register file with one synchronous write port, one combinational read port, and asynchronous clear on `rst`. The loader FSM, counter and checksum stay in `td4_imem_loader`.

## Test plan
- Reset: assert `rst` 2 cycles.
  - During reset: `cpu_rst`=1, `ld_ready`=0, `data`=00 for `addr` 0..F.
  - After release: state remains EMPTY with `cpu_rst` still 1.
- Full load with `ld_valid` held high: pulse `ld_start`, stream bytes 8'hB3, 8'h01, … (16 bytes).
  - `cpu_rst` falls on the last accepting edge.
  - `data`@`addr`=0 reads B3, `addr`=1 reads 01.
  - With `td4` attached, `port_o` shows 3 (OUT 3 program).
- Back-pressure gaps: toggle `ld_valid` every other cycle.
  - Exactly 16 writes occur, in order.
  - The load completes in 32 cycles with correct contents.
- Restart mid-load: after 7 bytes, `ld_start` asserted in the same cycle as `ld_valid` with byte 8'hFF.
  - FF is not written.
  - The counter restarts at 0 and the next byte lands at `addr` 0.
- Checksum (macro defined):
  - 16 bytes summing to 8'h40 followed by 8'hC0 → RUN, `err`=0.
  - The same image followed by 8'hC1 → ERROR with `err`=1 and `cpu_rst`=1, until the next `ld_start`.
- Async reset mid-load: assert `rst` between clock edges after byte 9.
  - Outputs return to reset values before the next edge.
  - All memory words read 00.
